// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The master drives the request and operands; the slave returns status and result.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  busy,
        input  done,
        input  diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  overflow,
`endif
        input  borrow_out
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output busy,
        output done,
        output diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output overflow,
`endif
        output borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop replaces a WIDTH-wide borrow chain.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds a signed-overflow flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_bit;
    logic             sub_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    always_comb begin
        sub_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        sub_borrow = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    end

    // Next-state and datapath update; the final borrow/overflow are latched on the last shift so they are valid while done is high.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                diff_d   = {sub_bit, diff_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = sub_borrow;
                if (cnt_q == LAST_BIT) begin
                    borrow_out_d = sub_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d        = (a_msb_q != b_msb_q) && (sub_bit != a_msb_q);
`endif
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    // Status flags decode directly from the state; results come from registers.
    always_comb begin
        bus.ready      = (state_q == IDLE);
        bus.busy       = (state_q == SHIFT);
        bus.done       = (state_q == DONE);
        bus.diff       = diff_q;
        bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        bus.overflow   = ovf_q;
`endif
    end
endmodule
